// File: rtl/lf_pkg.sv
// rtl/lf_pkg.sv - shared types and saturation helper for the PI loop filter
`ifndef VCO_N
`define VCO_N 15
`endif

package lf_pkg;

   typedef enum logic {LF_ACQ = 1'b0, LF_TRACK = 1'b1} lf_state_e;

   // Clamp a signed value into the range of a signed word of the given width.
   function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/lf_lock_det.sv
// rtl/lf_lock_det.sv - lock detector selecting acquisition or tracking gains
module lf_lock_det
   import lf_pkg::*;
#(
   parameter int IN_W       = 16,
   parameter int LOCK_TH    = 256,
   parameter int LOCK_CNT   = 64,
   parameter int UNLOCK_CNT = 16
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic                   hold,
   input  logic signed [IN_W-1:0] lf_in,
   output logic                   locked,
   output lf_state_e              gain_sel
);

   localparam int MAX_CNT = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
   localparam int CW      = $clog2(MAX_CNT + 1);

   lf_state_e           state;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_inc;
   logic signed [IN_W:0] ext;
   logic [IN_W:0]       mag;
   logic                big_err;

   // Error magnitude one bit wider so the most negative input has a valid magnitude.
   always_comb begin
      ext     = (IN_W + 1)'(lf_in);
      mag     = ext[IN_W] ? -ext : ext;
      big_err = (mag > (IN_W + 1)'(LOCK_TH));
      cnt_inc = cnt + CW'(1);
   end

   // Consecutive-sample qualification; hold freezes state and counter.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state  <= LF_ACQ;
         cnt    <= '0;
         locked <= 1'b0;
      end else if (clk_en && !hold) begin
         case (state)
            LF_ACQ: begin
               if (big_err) begin
                  cnt <= '0;
               end else if (cnt_inc == CW'(LOCK_CNT)) begin
                  state  <= LF_TRACK;
                  locked <= 1'b1;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            LF_TRACK: begin
               if (!big_err) begin
                  cnt <= '0;
               end else if (cnt_inc == CW'(UNLOCK_CNT)) begin
                  state  <= LF_ACQ;
                  locked <= 1'b0;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state  <= LF_ACQ;
               locked <= 1'b0;
               cnt    <= '0;
            end
         endcase
      end
   end

   assign gain_sel = state;

endmodule

// File: rtl/lf_pi_gs.sv
// rtl/lf_pi_gs.sv - gear-shifted PI loop filter with anti-windup and lock detect
module lf_pi_gs
   import lf_pkg::*;
#(
   parameter int IN_W       = 16,
   parameter int COEF_W     = 16,
   parameter int ACC_W      = 32,
   parameter int OUT_W      = `VCO_N + 1,
   parameter int FRAC       = 18,
   parameter int KP_ACQ     = 4096,
   parameter int KI_ACQ     = 16,
   parameter int KP_TRK     = 1024,
   parameter int KI_TRK     = 3,
   parameter int LOCK_TH    = 256,
   parameter int LOCK_CNT   = 64,
   parameter int UNLOCK_CNT = 16
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic signed [IN_W-1:0]  lf_in,
   input  logic                    hold,
   output logic signed [OUT_W-1:0] lf_out,
   output logic                    lf_valid,
   output logic                    locked
);

   localparam int PW = IN_W + COEF_W;

   lf_state_e                gain_sel;
   logic signed [COEF_W-1:0] kp;
   logic signed [COEF_W-1:0] ki;
   logic signed [PW-1:0]     kp_prod;
   logic signed [PW-1:0]     ki_prod;
   logic signed [PW-1:0]     p;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W:0]    acc_sum;
   logic signed [ACC_W:0]    pi_sum;
   logic signed [ACC_W:0]    pi_shift;
   logic                     s1_vld;

   lf_lock_det #(
      .IN_W       (IN_W),
      .LOCK_TH    (LOCK_TH),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT)
   ) u_lock_det (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .hold     (hold),
      .lf_in    (lf_in),
      .locked   (locked),
      .gain_sel (gain_sel)
   );

   // Gain selection, products and the one-bit-wider sums feeding both saturators.
   always_comb begin
      kp       = (gain_sel == LF_TRACK) ? COEF_W'(KP_TRK) : COEF_W'(KP_ACQ);
      ki       = (gain_sel == LF_TRACK) ? COEF_W'(KI_TRK) : COEF_W'(KI_ACQ);
      kp_prod  = PW'(kp) * PW'(lf_in);
      ki_prod  = PW'(ki) * PW'(lf_in);
      acc_sum  = (ACC_W + 1)'(acc) + (ACC_W + 1)'(ki_prod);
      acc_next = ACC_W'(sat(64'(acc_sum), ACC_W));
      pi_sum   = (ACC_W + 1)'(p) + (ACC_W + 1)'(acc);
      pi_shift = pi_sum >>> FRAC;
   end

   // Stage 1: register the proportional term and advance the clamped integrator.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         p      <= '0;
         acc    <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= clk_en;
         if (clk_en) begin
            p <= kp_prod;
            if (!hold) begin
               acc <= acc_next;
            end
         end
      end
   end

   // Stage 2: scale, saturate and publish the tuning word with a valid strobe.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         lf_out   <= '0;
         lf_valid <= 1'b0;
      end else begin
         lf_valid <= s1_vld;
         if (s1_vld) begin
            lf_out <= OUT_W'(sat(64'(pi_shift), OUT_W));
         end
      end
   end

endmodule

// File: tb/tb_lf_pi_gs.sv
// tb/tb_lf_pi_gs.sv - randomized self-checking bench for lf_pi_gs
module tb_lf_pi_gs;

   localparam int IN_W  = 16;
   localparam int OUT_W = 16;
   localparam int FRAC  = 18;

   logic                    sys_clk = 1'b0;
   logic                    rst     = 1'b1;
   logic                    clk_en  = 1'b0;
   logic signed [IN_W-1:0]  lf_in   = '0;
   logic                    hold    = 1'b0;
   logic signed [OUT_W-1:0] lf_out;
   logic                    lf_valid;
   logic                    locked;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit     m_trk   = 0;
   int     m_cnt   = 0;
   longint m_acc   = 0;
   longint m_p     = 0;
   bit     m_s1    = 0;
   longint e_out   = 0;
   bit     e_valid = 0;

   lf_pi_gs #(.OUT_W(OUT_W)) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .lf_in    (lf_in),
      .hold     (hold),
      .lf_out   (lf_out),
      .lf_valid (lf_valid),
      .locked   (locked)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic longint clamp(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // Drive one clock of stimulus, advance the model, return at the falling edge.
   task automatic cycle(input bit r, input bit en, input int x, input bit h);
      longint kp;
      longint ki;
      longint mag;
      rst    = r;
      clk_en = en;
      lf_in  = IN_W'(x);
      hold   = h;
      @(posedge sys_clk);
      if (r) begin
         m_trk = 0; m_cnt = 0; m_acc = 0; m_p = 0; m_s1 = 0; e_out = 0; e_valid = 0;
      end else begin
         if (m_s1) begin
            e_out   = clamp((m_p + m_acc) >>> FRAC, OUT_W);
            e_valid = 1;
         end else begin
            e_valid = 0;
         end
         m_s1 = en;
         if (en) begin
            kp  = m_trk ? 1024 : 4096;
            ki  = m_trk ? 3 : 16;
            m_p = kp * x;
            if (!h) begin
               m_acc = clamp(m_acc + ki * x, 32);
               mag   = (x < 0) ? -x : x;
               if (!m_trk) begin
                  m_cnt = (mag <= 256) ? m_cnt + 1 : 0;
                  if (m_cnt == 64) begin m_trk = 1; m_cnt = 0; end
               end else begin
                  m_cnt = (mag > 256) ? m_cnt + 1 : 0;
                  if (m_cnt == 16) begin m_trk = 0; m_cnt = 0; end
               end
            end
         end
      end
      @(negedge sys_clk);
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 1, 1234, 0);
      n_tests++;
      if (lf_out !== '0 || lf_valid !== 1'b0 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: lf_out=%0d lf_valid=%0b locked=%0b required 0/0/0", lf_out, lf_valid, locked);
      end
   endtask

   task automatic test_single();
      cycle(1, 0, 0, 0);
      cycle(0, 1, 64, 0);
      n_tests++;
      if (lf_valid !== 1'b0 || dut.p !== 32'sd262144 || dut.acc !== 32'sd1024) begin
         n_fail++;
         $display("FAIL single_s1: valid=%0b p=%0d acc=%0d required 0/262144/1024", lf_valid, dut.p, dut.acc);
      end
      cycle(0, 0, 0, 0);
      n_tests++;
      if (lf_valid !== 1'b1 || lf_out !== 16'sd1) begin
         n_fail++;
         $display("FAIL single_out: valid=%0b lf_out=%0d required 1/1", lf_valid, lf_out);
      end
      cycle(0, 0, 0, 0);
      n_tests++;
      if (lf_valid !== 1'b0 || lf_out !== 16'sd1) begin
         n_fail++;
         $display("FAIL single_hold: valid=%0b lf_out=%0d required 0/1", lf_valid, lf_out);
      end
   endtask

   task automatic test_floor();
      cycle(1, 0, 0, 0);
      cycle(0, 1, -1, 0);
      cycle(0, 0, 0, 0);
      n_tests++;
      if (lf_valid !== 1'b1 || lf_out !== -16'sd1) begin
         n_fail++;
         $display("FAIL floor: valid=%0b lf_out=%0d required 1/-1", lf_valid, lf_out);
      end
   endtask

   task automatic test_saturation();
      int bad;
      bad = 0;
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 4200; i++) begin
         cycle(0, 1, 32767, 0);
         if (lf_out !== OUT_W'(e_out) || lf_valid !== e_valid) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL sat_track: %0d cycles differed from model, required 0", bad);
      end
      n_tests++;
      if (lf_out !== 16'sd8703 || dut.acc !== 32'sh7fffffff) begin
         n_fail++;
         $display("FAIL sat_final: lf_out=%0d acc=%0d required 8703/2147483647", lf_out, dut.acc);
      end
   endtask

   task automatic test_lock_entry();
      int bad;
      bad = 0;
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 63; i++) begin
         cycle(0, 1, 200, 0);
         if (locked !== 1'b0) bad++;
      end
      cycle(0, 1, 257, 0);
      if (locked !== 1'b0) bad++;
      for (int i = 0; i < 63; i++) begin
         cycle(0, 1, 200, 0);
         if (locked !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL lock_early: locked high on %0d samples, required 0", bad);
      end
      cycle(0, 1, 200, 0);
      n_tests++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_rise: locked=%0b required 1", locked);
      end
      cycle(0, 1, 256, 0);
      n_tests++;
      if (dut.p !== 32'sd262144 || lf_out !== OUT_W'(e_out)) begin
         n_fail++;
         $display("FAIL lock_gain: p=%0d lf_out=%0d required 262144/%0d", dut.p, lf_out, e_out);
      end
      cycle(0, 0, 0, 0);
      n_tests++;
      if (lf_out !== OUT_W'(e_out) || lf_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_out: lf_out=%0d valid=%0b required %0d/1", lf_out, lf_valid, e_out);
      end
   endtask

   task automatic test_unlock();
      int bad;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         cycle(0, 1, -300, 0);
         if (locked !== 1'b1) bad++;
      end
      cycle(0, 1, 0, 0);
      if (locked !== 1'b1) bad++;
      for (int i = 0; i < 15; i++) begin
         cycle(0, 1, -300, 0);
         if (locked !== 1'b1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL unlock_early: locked low on %0d samples, required 0", bad);
      end
      cycle(0, 1, -300, 0);
      n_tests++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL unlock_fall: locked=%0b required 0", locked);
      end
   endtask

   task automatic test_hold();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1000, 1);
      cycle(0, 0, 0, 0);
      n_tests++;
      if (dut.acc !== 32'sd0 || locked !== 1'b0 || lf_out !== 16'sd15 || lf_out !== OUT_W'(e_out)) begin
         n_fail++;
         $display("FAIL hold: acc=%0d locked=%0b lf_out=%0d required 0/0/15", dut.acc, locked, lf_out);
      end
   endtask

   task automatic test_rst_kill();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 5000, 0);
      cycle(1, 0, 0, 0);
      n_tests++;
      if (lf_valid !== 1'b0 || lf_out !== '0 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_kill: valid=%0b lf_out=%0d locked=%0b required 0/0/0", lf_valid, lf_out, locked);
      end
      cycle(0, 0, 0, 0);
      n_tests++;
      if (lf_valid !== 1'b0 || lf_out !== '0) begin
         n_fail++;
         $display("FAIL rst_kill_after: valid=%0b lf_out=%0d required 0/0", lf_valid, lf_out);
      end
   endtask

   task automatic test_random();
      int  x;
      bit  r;
      bit  en;
      bit  h;
      int  bad;
      for (int blk = 0; blk < 6; blk++) begin
         bad = 0;
         for (int i = 0; i < 150; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 3) != 0);
            h  = ($urandom_range(0, 15) == 0);
            if ((blk % 2) == 0) begin
               x = ($urandom_range(0, 31) == 0) ? int'($signed(16'($urandom))) : $urandom_range(0, 500) - 250;
            end else begin
               x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 500) - 250 : int'($signed(16'($urandom)));
            end
            cycle(r, en, x, h);
            if (lf_out !== OUT_W'(e_out) || lf_valid !== e_valid || locked !== m_trk) begin
               bad++;
               if (bad == 1) begin
                  $display("FAIL random_cycle: blk=%0d i=%0d lf_out=%0d valid=%0b locked=%0b required %0d/%0b/%0b",
                           blk, i, lf_out, lf_valid, locked, e_out, e_valid, m_trk);
               end
            end
         end
         n_tests++;
         if (bad != 0) n_fail++;
      end
   endtask

   initial begin
      @(negedge sys_clk);
      test_reset();
      test_single();
      test_floor();
      test_saturation();
      test_lock_entry();
      test_unlock();
      test_hold();
      test_rst_kill();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
